// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like master bus between fetch and load/store.
// Data port wins ties; a grant streak counter forces fetch through eventually.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic        pick_data;
  logic        in_addr;
  logic        in_data;
  logic        aok;
  logic        dok;

  // Data wins unless fetch has waited through LIMIT data grants.
  assign pick_data = data_req & (~inst_req | (streak_q < LIMIT));

  // Next-state, owner and starvation streak.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    unique case (state_q)
      IDLE: begin
        if (inst_req | data_req) begin
          state_d = ADDR;
          owner_d = pick_data;
          if (pick_data && inst_req) begin
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_d = bus_data_ok ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign aok     = in_addr & bus_addr_ok;
  assign dok     = (aok & bus_data_ok) | (in_data & bus_data_ok);

  // Handshake pulses and read data steered to the current owner only.
  always_comb begin
    inst_addr_ok = aok & ~owner_q;
    data_addr_ok = aok & owner_q;
    inst_data_ok = dok & ~owner_q;
    data_data_ok = dok & owner_q;
    inst_rdata   = (dok & ~owner_q) ? bus_rdata : 32'd0;
    data_rdata   = (dok & owner_q) ? bus_rdata : 32'd0;
  end

  // Master bus fields follow the owner's inputs while in ADDR.
  always_comb begin
    bus_req   = in_addr;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (in_addr) begin
      if (owner_q) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_size  = 2'd2;
        bus_addr  = inst_addr;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory master bus between instruction fetch (inst port) and load/store (data port) of the MIPS pipeline.
- Sits between the datapath's fetch/memory stages and the bus bridge.
- Handles one outstanding transaction at a time.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced through (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
inst_addr  in  32  fetch address
inst_addr_ok  out  1  one-cycle pulse: fetch address accepted
inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
inst_rdata  out  32  fetched word
data_req  in  1  load/store request; held with fields until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  one-cycle pulse: data address accepted
data_data_ok  out  1  one-cycle pulse: load data valid / store done
data_rdata  out  32  load data
bus_req  out  1  master request
bus_wr  out  1  master write
bus_size  out  2  master size
bus_addr  out  32  master address
bus_wdata  out  32  master write data
bus_addr_ok  in  1  slave accepted address
bus_data_ok  in  1  slave returned data / write done
bus_rdata  in  32  slave read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, owner = INST, streak = 0.
  - All outputs 0, including bus_req, every *_ok pulse and busy.
- Reset mid-transaction aborts it. bus_data_ok/bus_addr_ok arriving while IDLE are ignored.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - No request pending: stay in IDLE.
  - Any request pending: pick owner, go to ADDR next cycle. Arbitration costs exactly one cycle.
- Owner selection:
  - Only one requester: that requester.
  - Both requesting and streak < STARVE_LIMIT: DATA.
  - Both requesting and streak >= STARVE_LIMIT: INST.
- streak counter:
  - DATA grant with inst_req high: streak += 1, saturating at 15.
  - DATA grant with inst_req low: streak = 0.
  - INST grant: streak = 0.
- ADDR:
  - bus_req = 1. bus_wr/size/addr/wdata driven combinationally from the owner's inputs.
  - INST owner drives bus_wr = 0, bus_size = 2, bus_wdata = 0.
  - On bus_addr_ok: pulse owner's *_addr_ok in the same cycle, go to DATA.
  - If bus_data_ok is also high in that cycle: pulse owner's *_data_ok too, go straight to IDLE.
- DATA:
  - bus_req = 0.
  - On bus_data_ok: pulse owner's *_data_ok, drive owner's *_rdata = bus_rdata in that cycle, go to IDLE.
- *_rdata: 0 whenever that port's *_data_ok is low.
- Non-owner's *_ok outputs are always 0.
- Requester dropping *_req while in ADDR before addr_ok is illegal; the block keeps owner and does not check for it.
- Minimum transaction: IDLE→ADDR→DATA→IDLE = 3 cycles with a 1-cycle slave. Next arbitration happens in the IDLE cycle after completion.
- busy = (state != IDLE). The datapath uses it for stall generation.

Test Plan:
- Reset mid-transaction: single inst fetch 0xBFC00000, slave addr_ok 1 cycle after bus_req, data_ok 1 cycle later with 0x3C08BFAF -> inst_addr_ok pulse in ADDR, inst_data_ok pulse with inst_rdata = 0x3C08BFAF, state back to IDLE. Then pull resetn low while in DATA, with bus_data_ok arriving after release -> all outputs 0 immediately, no *_data_ok pulse.
- Simultaneous requests (inst 0xBFC00004, load word 0x80001000) -> data granted first (bus_addr = 0x80001000, bus_wr = 0), inst granted on the following arbitration, streak returns to 0.
- Starvation: inst_req held high, data_req held high for 6 back-to-back stores, STARVE_LIMIT = 4 -> exactly 4 data grants, then 1 inst grant, then data resumes.
- Zero-latency slave: bus_addr_ok and bus_data_ok asserted in the same ADDR cycle on a store (size = 0, addr 0x80000003, wdata 0xAB) -> data_addr_ok and data_data_ok pulse together, FSM ADDR→IDLE directly.
- Spurious slave response: bus_data_ok = 1 with bus_rdata = 0xDEADBEEF while IDLE -> no *_data_ok, both *_rdata stay 0.
- Store fields: store half at 0x80000002, wdata 0x1234, slave stretches bus_addr_ok by 3 cycles -> bus_req, bus_wr = 1, bus_size = 1, bus_addr, bus_wdata stable for all 4 ADDR cycles; data_addr_ok pulses once.
